// File: rtl/mycpu_pkg.sv
// Shared types and constants for the 1-to-3 demultiplexer with per-port
// one-entry slots.
package mycpu_pkg;

  // Number of destination ports served by the demux.
  localparam int NUM_DEST = 3;

  // Destination select; encodings 0..2 address a port, 3 is illegal.
  typedef logic [1:0] dest_sel_t;

  localparam dest_sel_t SEL_ILLEGAL = 2'd3;

  // Occupancy of a one-entry output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // True when the select addresses a real port.
  function automatic logic sel_is_legal(input dest_sel_t sel);
    return sel != SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/demux_1x3x16_svamod.sv
// Checker companion for demux_1x3x16: unknown-value checks on all ports,
// hold-under-stall of each port's data, and the illegal-select drop rule.
module demux_1x3x16_svamod (
  input logic        clk,
  input logic        rst_n,
  input logic        in_valid,
  input logic        in_ready,
  input logic [1:0]  sel_in,
  input logic [15:0] d_in,
  input logic [15:0] q0_out,
  input logic [15:0] q1_out,
  input logic [15:0] q2_out,
  input logic [2:0]  v_out,
  input logic [2:0]  r_in,
  input logic        err_out
);
  import mycpu_pkg::*;

  logic                      seen_rst_q, seen_rst_d;
  logic [NUM_DEST-1:0][15:0] q_all;
  logic                      drop;

  assign q_all = {q2_out, q1_out, q0_out};
  assign drop  = rst_n && in_valid && (sel_in == SEL_ILLEGAL);

  // Outputs are only defined once a reset has been sampled.
  always_comb begin
    seen_rst_d = seen_rst_q | ~rst_n;
  end

  // Remember that a reset edge has occurred.
  always_ff @(posedge clk) begin
    seen_rst_q <= seen_rst_d;
  end

  a_in_known: assert property (@(posedge clk)
    !$isunknown({rst_n, in_valid, sel_in, d_in, r_in}));

  a_out_known: assert property (@(posedge clk)
    seen_rst_q |-> !$isunknown({in_ready, q0_out, q1_out, q2_out, v_out, err_out}));

  a_err_on_drop: assert property (@(posedge clk) drop |=> err_out);

  a_err_only_on_drop: assert property (@(posedge clk) !drop |=> !err_out);

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_port
    a_hold_on_stall: assert property (@(posedge clk)
      (rst_n && v_out[k] && !r_in[k]) |=> (v_out[k] && $stable(q_all[k])));

    a_drop_no_change: assert property (@(posedge clk)
      (drop && !(v_out[k] && r_in[k])) |=> ($stable(v_out[k]) && $stable(q_all[k])));
  end

endmodule

// File: rtl/demux_slot16.sv
// One-entry 16-bit output slot with valid/ready handshake on the drain side.
// can_load_out tells the demux whether a word may be written this cycle
// (slot empty, or its current word leaves in the same cycle).
module demux_slot16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_in,
  input  logic [15:0] d_in,
  input  logic        rdy_in,
  output logic        valid_out,
  output logic [15:0] q_out,
  output logic        can_load_out
);
  import mycpu_pkg::*;

  slot_state_t state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        drain;

  // Next-state and data-capture logic for the slot.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    data_d  = data_q;
    drain   = (state_q == SLOT_FULL) && rdy_in;

    case (state_q)
      SLOT_EMPTY: begin
        if (load_in) state_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        // A load while full only happens alongside a drain; the slot stays full.
        if (load_in)    state_d = SLOT_FULL;
        else if (drain) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase

    if (load_in) data_d = d_in;
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      // NOTE: the data register is reset because the held output must read zero after reset, not stale contents.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_out    = (state_q == SLOT_FULL);
  assign q_out        = data_q;
  assign can_load_out = (state_q == SLOT_EMPTY) || drain;

endmodule

// File: rtl/demux_1x3x16.sv
// 1-to-3 demultiplexer for 16-bit words. Each destination owns a one-entry
// slot so a stalled port never blocks traffic to the others. Words with the
// illegal select are accepted, dropped, and flagged with a one-cycle err_out.
// Optional feature: define DEMUX_ERRCNT_EN to add err_cnt_out, a saturating
// count of dropped words.
module demux_1x3x16 #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  sel_in,
  input  logic [15:0] d_in,
  output logic [15:0] q0_out,
  output logic [15:0] q1_out,
  output logic [15:0] q2_out,
  output logic [2:0]  v_out,
  input  logic [2:0]  r_in,
  output logic        err_out
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt_out
`endif
);
  import mycpu_pkg::*;

  logic [NUM_DEST-1:0]       slot_load;
  logic [NUM_DEST-1:0]       slot_can_load;
  logic [NUM_DEST-1:0][15:0] slot_q;
  logic                      err_q, err_d;

  // Ready depends only on the addressed slot, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (sel_in)
      2'd0:    in_ready = slot_can_load[0];
      2'd1:    in_ready = slot_can_load[1];
      2'd2:    in_ready = slot_can_load[2];
      default: in_ready = 1'b1;
    endcase
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    assign slot_load[k] = in_valid && in_ready && (sel_in == dest_sel_t'(k));

    demux_slot16 u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_in      (slot_load[k]),
      .d_in         (d_in),
      .rdy_in       (r_in[k]),
      .valid_out    (v_out[k]),
      .q_out        (slot_q[k]),
      .can_load_out (slot_can_load[k])
    );
  end

  assign q0_out = slot_q[0];
  assign q1_out = slot_q[1];
  assign q2_out = slot_q[2];

  // Flag an accepted word that carries the illegal select.
  always_comb begin
    err_d = in_valid && in_ready && !sel_is_legal(sel_in);
  end

  // One-cycle error pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_out = err_q;

`ifdef DEMUX_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count each drop in the same cycle its err_out pulse appears; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_cnt_out = cnt_q;
`else
  // Counter width is meaningless without the counter; tie it off.
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: doc/demux_1x3x16.md
DEMUX_1X3X16 -- requirements
Module: demux_1x3x16

Interface
REQ-001 Parameter: CNT_W, default 8, width of the illegal-select drop counter.
REQ-002 Clocking: one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 sel_in  input  2  destination port 0..2; value 3 is illegal.
REQ-008 d_in  input  16  data word.
REQ-009 q0_out, q1_out, q2_out  output  16 each  per-port held data.
REQ-010 v_out  output  3  per-port valid; bit k belongs to qk_out.
REQ-011 r_in  input  3  per-port downstream ready.
REQ-012 err_out  output  1  one-cycle pulse when an illegal-select word is dropped.
REQ-013 err_cnt_out  output  CNT_W  drop count; present only when DEMUX_ERRCNT_EN is defined.

Function
REQ-014 Each port SHALL be a one-entry slot with states EMPTY and FULL.
REQ-015 Transfer in SHALL occur when in_valid && in_ready.
REQ-016 Transfer out on port k SHALL occur when v_out[k] && r_in[k].
REQ-017 in_ready SHALL be combinational: 1 if sel_in==3; otherwise 1 if slot[sel_in] is EMPTY or transfers out this cycle.
REQ-018 in_ready SHALL NOT depend on in_valid.
REQ-019 On transfer in with legal sel_in=k, slot k SHALL capture d_in, and go FULL with v_out[k]=1 on the next cycle (latency 1).
REQ-020 Slot transitions: EMPTY->FULL on load; FULL->EMPTY on drain without load; FULL->FULL on simultaneous drain and load, with the new data replacing the old.
REQ-021 qk_out SHALL remain stable while v_out[k]=1 and r_in[k]=0.
REQ-022 Slots SHALL drain independently; a stalled port SHALL NOT block words addressed to other ports.
REQ-023 Word order into any single port SHALL be preserved.
REQ-024 On transfer in with sel_in==3, the word SHALL be dropped, no slot SHALL change, and err_out SHALL be 1 on the next cycle only.
REQ-025 When no transfer occurs, sel_in and d_in SHALL be ignored.

Reset
REQ-026 While rst_n=0 at a clk edge, all slots SHALL go EMPTY, v_out=3'b000, q0..q2_out=16'h0000, err_out=0 and err_cnt_out=0.
REQ-027 A reset asserted while slots are FULL SHALL discard their contents with no transfer out.
REQ-028 in_ready SHALL follow REQ-017 from the first cycle after reset.

Configuration
REQ-029 Macro DEMUX_ERRCNT_EN: when defined, err_cnt_out SHALL exist and increment on each err_out pulse, saturating at 2^CNT_W-1.
REQ-030 When DEMUX_ERRCNT_EN is undefined, the port and counter SHALL be absent, and err_out behaviour SHALL be unchanged.

Structure
REQ-031 mycpu_pkg SHALL hold the dest_sel_t 2-bit typedef, the constant NUM_DEST=3, the constant SEL_ILLEGAL=2'd3 and the slot state enum.
REQ-032 The per-port slot SHALL be a sub-module demux_slot16, instantiated three times.
REQ-033 A companion demux_1x3x16_svamod SHALL apply xcheck to all ports and assert REQ-021 and REQ-024.

Verification
REQ-034 Reset, then sel_in=1, d_in=16'hA5A5, in_valid=1 for 1 cycle, r_in=3'b000 -> next cycle v_out=3'b010, q1_out=16'hA5A5, held for 5 stalled cycles.
REQ-035 Port 0 FULL with r_in[0]=0, then sel_in=0 offered -> in_ready=0; then a sel_in=2 word 16'h1234 -> accepted, q2_out=16'h1234 next cycle.
REQ-036 Port 2 FULL with r_in[2]=1 and a simultaneous sel_in=2 load of 16'hBEEF -> v_out[2] stays 1, q2_out=16'hBEEF next cycle.
REQ-037 Three consecutive sel_in=3 words -> in_ready=1 each cycle, err_out high for 3 cycles, v_out unchanged, err_cnt_out=3 when DEMUX_ERRCNT_EN is defined.
REQ-038 All three slots FULL, rst_n=0 for one edge -> v_out=0, all q*_out=0, err_cnt_out=0.
REQ-039 With DEMUX_ERRCNT_EN defined and CNT_W=2, five illegal words -> err_cnt_out sequence 1,2,3,3,3.
